// File: rtl/tl_ul_a_queue.sv
// TileLink-UL A-channel queue: circular buffer with optional empty bypass, plus
// per-source inflight tracking and protocol error flags.
module tl_ul_a_queue #(
   parameter int unsigned DEPTH = 2,
   parameter bit          FLOW  = 1'b0
) (
   input  logic                   clock,
   input  logic                   reset_n,

   input  logic                   in_a_valid,
   output logic                   in_a_ready,
   input  logic [2:0]             in_a_opcode,
   input  logic [2:0]             in_a_param,
   input  logic [1:0]             in_a_size,
   input  logic [1:0]             in_a_source,
   input  logic [29:0]            in_a_address,
   input  logic [3:0]             in_a_mask,
   input  logic [31:0]            in_a_data,

   output logic                   out_a_valid,
   input  logic                   out_a_ready,
   output logic [2:0]             out_a_opcode,
   output logic [2:0]             out_a_param,
   output logic [1:0]             out_a_size,
   output logic [1:0]             out_a_source,
   output logic [29:0]            out_a_address,
   output logic [3:0]             out_a_mask,
   output logic [31:0]            out_a_data,

   input  logic                   d_fire,
   input  logic [1:0]             d_source,
   output logic [3:0]             inflight,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err_dup_source,
   output logic                   err_orphan_d
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned PW = 76;
   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   logic [PW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    inflight_q, inflight_d;
   logic          dup_q, dup_d, orphan_q, orphan_d;

   logic [PW-1:0] in_beat, head_beat, out_beat;
   logic          empty, in_fire, out_fire, push, pop;
   logic [3:0]    set_mask, clr_mask;

   assign in_beat   = {in_a_opcode, in_a_param, in_a_size, in_a_source,
                       in_a_address, in_a_mask, in_a_data};
   assign head_beat = mem_q[rptr_q];
   assign empty     = (count_q == '0);

   always_comb begin
      in_a_ready  = (count_q != FullCount) | out_a_ready;
      out_a_valid = !empty | (FLOW & in_a_valid);
      out_beat    = (FLOW && empty) ? in_beat : head_beat;
   end

   assign {out_a_opcode, out_a_param, out_a_size, out_a_source,
           out_a_address, out_a_mask, out_a_data} = out_beat;

   assign in_fire  = in_a_valid & in_a_ready;
   assign out_fire = out_a_valid & out_a_ready;
   // An out fire while empty can only be the bypass path: nothing is stored or popped.
   assign push     = in_fire & ~(empty & out_fire);
   assign pop      = out_fire & ~empty;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      set_mask   = out_fire ? (4'b0001 << out_a_source) : 4'b0000;
      clr_mask   = d_fire ? (4'b0001 << d_source) : 4'b0000;
      // Set is applied after clear so a new request wins over a same-cycle response.
      inflight_d = (inflight_q & ~clr_mask) | set_mask;
      dup_d      = out_fire & inflight_q[out_a_source];
      orphan_d   = d_fire & ~inflight_q[d_source];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         dup_q      <= 1'b0;
         orphan_q   <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         dup_q      <= dup_d;
         orphan_q   <= orphan_d;
      end
   end

   // Payload storage is deliberately left without reset.
   always_ff @(posedge clock) begin
      if (push) mem_q[wptr_q] <= in_beat;
   end

   assign count          = count_q;
   assign inflight       = inflight_q;
   assign err_dup_source = dup_q;
   assign err_orphan_d   = orphan_q;

endmodule

// File: tb/tb_tl_ul_a_queue.sv
// Directed bench for tl_ul_a_queue: vector table on a DEPTH=2/FLOW=0 instance, plus
// hand sequences for asynchronous reset and the FLOW=1 bypass.
module tb_tl_ul_a_queue;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_a_valid, out_a_ready, d_fire;
   logic [2:0]  in_a_opcode, in_a_param;
   logic [1:0]  in_a_size, in_a_source, d_source;
   logic [29:0] in_a_address;
   logic [3:0]  in_a_mask;
   logic [31:0] in_a_data;

   logic        in_a_ready, out_a_valid, err_dup_source, err_orphan_d;
   logic [2:0]  out_a_opcode, out_a_param;
   logic [1:0]  out_a_size, out_a_source;
   logic [29:0] out_a_address;
   logic [3:0]  out_a_mask, inflight;
   logic [31:0] out_a_data;
   logic [1:0]  count;

   logic        f_in_a_ready, f_out_a_valid, f_err_dup, f_err_orphan;
   logic [2:0]  f_out_a_opcode, f_out_a_param;
   logic [1:0]  f_out_a_size, f_out_a_source;
   logic [29:0] f_out_a_address;
   logic [3:0]  f_out_a_mask, f_inflight;
   logic [31:0] f_out_a_data;
   logic [1:0]  f_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   tl_ul_a_queue #(.DEPTH(2), .FLOW(1'b0)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
      .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
      .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
      .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
      .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
      .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
      .d_fire(d_fire), .d_source(d_source), .inflight(inflight), .count(count),
      .err_dup_source(err_dup_source), .err_orphan_d(err_orphan_d)
   );

   tl_ul_a_queue #(.DEPTH(2), .FLOW(1'b1)) u_dut_flow (
      .clock(clock), .reset_n(reset_n),
      .in_a_valid(in_a_valid), .in_a_ready(f_in_a_ready), .in_a_opcode(in_a_opcode),
      .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
      .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
      .out_a_valid(f_out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(f_out_a_opcode),
      .out_a_param(f_out_a_param), .out_a_size(f_out_a_size), .out_a_source(f_out_a_source),
      .out_a_address(f_out_a_address), .out_a_mask(f_out_a_mask), .out_a_data(f_out_a_data),
      .d_fire(d_fire), .d_source(d_source), .inflight(f_inflight), .count(f_count),
      .err_dup_source(f_err_dup), .err_orphan_d(f_err_orphan)
   );

   typedef struct {
      logic       iv;
      logic [1:0] isrc;
      logic [7:0] itag;
      logic       ordy;
      logic       dfire;
      logic [1:0] dsrc;
      logic [1:0] cnt;
      logic       irdy;
      logic       ovld;
      logic [1:0] osrc;
      logic [7:0] otag;
      logic [3:0] infl;
      logic       edup;
      logic       eorph;
   } vec_t;

   vec_t vecs[$];

   // Every payload field is derived from an 8-bit tag so one number identifies a beat.
   function automatic logic [29:0] tag_addr(input logic [7:0] t);
      return 30'h0ABC_0000 + {22'h0, t};
   endfunction
   function automatic logic [31:0] tag_data(input logic [7:0] t);
      return {t, ~t, t, 8'h5A};
   endfunction
   function automatic logic [3:0] tag_mask(input logic [7:0] t);
      return t[3:0] ^ 4'hF;
   endfunction

   function automatic vec_t mk(input logic iv, input logic [1:0] isrc, input logic [7:0] itag,
                               input logic ordy, input logic dfire, input logic [1:0] dsrc,
                               input logic [1:0] cnt, input logic irdy, input logic ovld,
                               input logic [1:0] osrc, input logic [7:0] otag,
                               input logic [3:0] infl, input logic edup, input logic eorph);
      vec_t v;
      v.iv = iv; v.isrc = isrc; v.itag = itag; v.ordy = ordy; v.dfire = dfire; v.dsrc = dsrc;
      v.cnt = cnt; v.irdy = irdy; v.ovld = ovld; v.osrc = osrc; v.otag = otag;
      v.infl = infl; v.edup = edup; v.eorph = eorph;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic iv, input logic [1:0] src, input logic [7:0] tag,
                         input logic ordy, input logic df, input logic [1:0] ds);
      in_a_valid   = iv;
      in_a_source  = src;
      in_a_opcode  = tag[2:0];
      in_a_param   = tag[5:3];
      in_a_size    = tag[7:6];
      in_a_address = tag_addr(tag);
      in_a_mask    = tag_mask(tag);
      in_a_data    = tag_data(tag);
      out_a_ready  = ordy;
      d_fire       = df;
      d_source     = ds;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0);
      #2;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_in_ready", 32'(in_a_ready), 32'd1);
      chk("reset_out_valid", 32'(out_a_valid), 32'd0);
      chk("reset_inflight", 32'(inflight), 32'd0);
      #20 reset_n = 1'b1;
      step();

      //          iv src tag   rdy df ds   cnt irdy ovld osrc otag  infl     dup orph
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 0, 8'h11, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 8'h22, 0, 0, 0, 1, 1, 1, 0, 8'h11, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 2, 8'h33, 0, 0, 0, 2, 0, 1, 0, 8'h11, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 2, 1, 1, 0, 8'h11, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1, 1, 1, 8'h22, 4'b0001, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b0011, 0, 0));
      vecs.push_back(mk(1, 2, 8'h44, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b0011, 0, 0));
      vecs.push_back(mk(1, 3, 8'h55, 0, 0, 0, 1, 1, 1, 2, 8'h44, 4'b0011, 0, 0));
      vecs.push_back(mk(1, 2, 8'h66, 1, 1, 0, 2, 1, 1, 2, 8'h44, 4'b0011, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 2, 1, 1, 3, 8'h55, 4'b0110, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1, 1, 2, 8'h66, 4'b1100, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b1100, 1, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 3, 0, 1, 0, 0, 8'h00, 4'b1100, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 2, 0, 1, 0, 0, 8'h00, 4'b0100, 0, 0));
      vecs.push_back(mk(1, 3, 8'h77, 1, 0, 0, 0, 1, 0, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 3, 8'h88, 1, 0, 0, 1, 1, 1, 3, 8'h77, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1, 1, 3, 8'h88, 4'b1000, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b1000, 1, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 3, 0, 1, 0, 0, 8'h00, 4'b1000, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 1, 0, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b0000, 0, 1));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 8'hA0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1, 1, 1, 8'hA0, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 8'hA1, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b0010, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 1, 1, 1, 8'hA1, 4'b0010, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'b0010, 1, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 1, 0, 0, 8'h00, 4'b0010, 0, 0));

      foreach (vecs[i]) begin
         set_in(vecs[i].iv, vecs[i].isrc, vecs[i].itag, vecs[i].ordy, vecs[i].dfire,
                vecs[i].dsrc);
         #2;
         chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
         chk($sformatf("v%0d_in_ready", i), 32'(in_a_ready), 32'(vecs[i].irdy));
         chk($sformatf("v%0d_out_valid", i), 32'(out_a_valid), 32'(vecs[i].ovld));
         chk($sformatf("v%0d_inflight", i), 32'(inflight), 32'(vecs[i].infl));
         chk($sformatf("v%0d_err_dup", i), 32'(err_dup_source), 32'(vecs[i].edup));
         chk($sformatf("v%0d_err_orphan", i), 32'(err_orphan_d), 32'(vecs[i].eorph));
         if (vecs[i].ovld) begin
            chk($sformatf("v%0d_out_source", i), 32'(out_a_source), 32'(vecs[i].osrc));
            chk($sformatf("v%0d_out_fields", i),
                32'({out_a_size, out_a_param, out_a_opcode}), 32'(vecs[i].otag));
            chk($sformatf("v%0d_out_address", i), 32'(out_a_address),
                32'(tag_addr(vecs[i].otag)));
            chk($sformatf("v%0d_out_mask", i), 32'(out_a_mask), 32'(tag_mask(vecs[i].otag)));
            chk($sformatf("v%0d_out_data", i), out_a_data, tag_data(vecs[i].otag));
         end
         step();
      end

      // Asynchronous reset with count=1 and inflight=0011.
      set_in(1'b1, 2'd0, 8'hB0, 1'b0, 1'b0, 2'd0); step();
      set_in(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0); step();
      set_in(1'b1, 2'd1, 8'hB1, 1'b0, 1'b0, 2'd0); step();
      set_in(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0); step();
      set_in(1'b1, 2'd2, 8'hB2, 1'b0, 1'b0, 2'd0); step();
      set_in(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0);
      chk("pre_reset_count", 32'(count), 32'd1);
      chk("pre_reset_inflight", 32'(inflight), 32'b0011);
      #1 reset_n = 1'b0;
      #1;
      chk("async_reset_count", 32'(count), 32'd0);
      chk("async_reset_inflight", 32'(inflight), 32'd0);
      chk("async_reset_out_valid", 32'(out_a_valid), 32'd0);
      chk("async_reset_in_ready", 32'(in_a_ready), 32'd1);
      set_in(1'b1, 2'd0, 8'hB3, 1'b0, 1'b0, 2'd0);
      step();
      chk("held_reset_count", 32'(count), 32'd0);
      #2 reset_n = 1'b1;
      #1;
      chk("release_count", 32'(count), 32'd0);
      step();
      chk("first_push_count", 32'(count), 32'd1);
      chk("first_push_out_valid", 32'(out_a_valid), 32'd1);
      chk("first_push_address", 32'(out_a_address), 32'(tag_addr(8'hB3)));

      // FLOW=1 bypass on a freshly reset, empty queue.
      set_in(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0);
      #1 reset_n = 1'b0;
      step();
      #2 reset_n = 1'b1;
      step();
      set_in(1'b1, 2'd2, 8'hC3, 1'b1, 1'b0, 2'd0);
      #2;
      chk("flow_out_valid", 32'(f_out_a_valid), 32'd1);
      chk("flow_in_ready", 32'(f_in_a_ready), 32'd1);
      chk("flow_out_source", 32'(f_out_a_source), 32'd2);
      chk("flow_out_address", 32'(f_out_a_address), 32'(tag_addr(8'hC3)));
      chk("flow_out_data", f_out_a_data, tag_data(8'hC3));
      step();
      chk("flow_count_after_bypass", 32'(f_count), 32'd0);
      chk("flow_inflight", 32'(f_inflight), 32'b0100);
      set_in(1'b1, 2'd1, 8'hC4, 1'b0, 1'b0, 2'd0);
      #2;
      chk("flow_stall_out_source", 32'(f_out_a_source), 32'd1);
      step();
      set_in(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0);
      #2;
      chk("flow_stored_count", 32'(f_count), 32'd1);
      chk("flow_stored_out_valid", 32'(f_out_a_valid), 32'd1);
      chk("flow_stored_data", f_out_a_data, tag_data(8'hC4));
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tl_ul_a_queue.md
TL_UL_A_QUEUE -- requirements
Module: tl_ul_a_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of A-channel entries (power of two, 2..8).
REQ-002 SHALL have parameter FLOW, default 0, meaning 1 = empty-queue combinational bypass from in to out.
REQ-003 SHALL have port clock, input, 1, meaning single rising-edge clock for all state.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous assert, active-low reset.
REQ-005 SHALL have port in_a_valid / in_a_ready, input / output, 1 / 1, meaning upstream A handshake.
REQ-006 SHALL have port in_a_opcode, in_a_param, in_a_size, in_a_source, input, 3 / 3 / 2 / 2, meaning A fields.
REQ-007 SHALL have port in_a_address, in_a_mask, in_a_data, input, 30 / 4 / 32, meaning A word address, byte mask and data.
REQ-008 SHALL have port out_a_valid / out_a_ready, output / input, 1 / 1, meaning downstream A handshake.
REQ-009 SHALL have ports out_a_* (all fields above), output, same widths, meaning queued A beat.
REQ-010 SHALL have port d_fire, input, 1, meaning a D beat completed downstream.
REQ-011 SHALL have port d_source, input, 2, meaning source of that D beat.
REQ-012 SHALL have port inflight, output, 4, meaning one bit per source with a request outstanding.
REQ-013 SHALL have port count, output, log2(DEPTH)+1, meaning entries held.
REQ-014 SHALL have port err_dup_source, output, 1, meaning registered; an out_a fire used a source already inflight.
REQ-015 SHALL have port err_orphan_d, output, 1, meaning registered; d_fire arrived for a source not inflight.

Function
REQ-016 SHALL implement a circular buffer with write pointer, read pointer and count, with pointers wrapping modulo DEPTH.
REQ-017 SHALL define in fire as in_a_valid & in_a_ready, and out fire as out_a_valid & out_a_ready.
REQ-018 SHALL drive in_a_ready = (count != DEPTH) | out_a_ready, so a full queue accepts a beat in the same cycle one drains.
REQ-019 SHALL drive out_a_valid = (count != 0), or, with FLOW=1, (count != 0) | in_a_valid.
REQ-020 SHALL drive out_a_* from the head entry when count != 0, else (FLOW=1) from in_a_*.
REQ-021 SHALL make an in fire write its entry at the write pointer and advance the pointer at the next edge; latency is 1 cycle with FLOW=0.
REQ-022 SHALL make an out fire advance the read pointer.
REQ-023 SHALL update count +1 on in fire only, -1 on out fire only, and leave it unchanged on both or neither.
REQ-024 SHALL NOT write the entry or move pointers on a FLOW bypass (count==0, in fire and out fire in the same cycle).
REQ-025 SHALL set inflight[src] on out fire with out_a_source=src, and clear inflight[src] on d_fire with d_source=src.
REQ-026 SHALL, when a set and a clear target the same source in one cycle, end with the bit set (new request wins).
REQ-027 SHALL raise err_dup_source for exactly one cycle after an out fire whose source bit was already 1.
REQ-028 SHALL raise err_orphan_d for exactly one cycle after a d_fire whose source bit was 0; inflight stays 0 in that case.
REQ-029 SHALL hold out_a_* and out_a_valid stable while out_a_valid & !out_a_ready (TileLink irrevocability).
REQ-030 SHALL leave data payload storage without reset; only control state resets.

Reset
REQ-031 SHALL, while reset_n=0, force count=0, pointers=0, inflight=0, err_dup_source=0, err_orphan_d=0, out_a_valid=0 (FLOW=0) and in_a_ready=1.
REQ-032 SHALL discard stored beats and inflight state on reset asserted mid-operation, with no output fire in that cycle.
REQ-033 SHALL release reset so that the first in fire is possible at the first rising edge after reset_n rises.

Verification
REQ-034 SHALL cover: DEPTH=2, FLOW=0, push sources 0,1 with out_a_ready=0 -> count=2, in_a_ready=0; then out_a_ready=1 -> out returns source 0 then 1, in order.
REQ-035 SHALL cover: queue full, simultaneous push (source 2) and pop -> count stays 2, and the 3rd beat out is source 2 with intact address/mask/data.
REQ-036 SHALL cover: out fire source 3 twice without d_fire -> err_dup_source=1 for one cycle after the second fire, and inflight=4'b1000.
REQ-037 SHALL cover: d_fire d_source=1 with inflight=0 -> err_orphan_d=1 for one cycle, and inflight stays 0.
REQ-038 SHALL cover: FLOW=1, empty, in_a_valid and out_a_ready both 1 -> same-cycle pass-through with count staying 0.
REQ-039 SHALL cover: reset_n pulsed low with count=1 and inflight=4'b0011 -> count=0, inflight=0, out_a_valid=0 immediately (asynchronous).
